// File: rtl/multi_stepper_driver.sv
// Multi-channel stepper motor driver.
// A shared step-rate tick advances one IDLE/MOVE/HOLD controller per channel.
// Each controller issues step pulses, keeps the coils energised for a hold
// period after the last step, and reports completion.
module multi_stepper_driver #(
  parameter int NUM_CH     = 2,
  parameter int STEP_W     = 12,
  parameter int HOLD_STEPS = 50
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     step_clock,
  input  logic [NUM_CH-1:0]        start,
  input  logic [NUM_CH-1:0]        dir_in,
  input  logic [NUM_CH*STEP_W-1:0] steps,
  input  logic [NUM_CH-1:0]        abort,
  output logic [NUM_CH-1:0]        en_n,
  output logic [NUM_CH-1:0]        step_out,
  output logic [NUM_CH-1:0]        dir_out,
  output logic [NUM_CH-1:0]        busy,
  output logic [NUM_CH-1:0]        done,
  output logic                     all_done
);

  // Hold counter must be at least one bit wide even when no hold is requested.
  localparam int HOLD_W = (HOLD_STEPS < 1) ? 1 : $clog2(HOLD_STEPS + 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MOVE = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  logic r_sc_meta;
  logic r_sc_sync;
  logic r_sc_prev;
  logic w_tick;
  logic r_all_done;

  // Two-flop synchroniser for step_clock plus a delayed copy for edge detection.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_sc_meta <= 1'b0;
      r_sc_sync <= 1'b0;
      r_sc_prev <= 1'b0;
    end else begin
      r_sc_meta <= step_clock;
      r_sc_sync <= r_sc_meta;
      r_sc_prev <= r_sc_sync;
    end
  end

  // One-clock tick on each synchronised rising edge, shared by all channels.
  assign w_tick = r_sc_sync & ~r_sc_prev;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
      state_t              r_state;
      logic [STEP_W-1:0]   r_cnt;
      logic [HOLD_W-1:0]   r_hold;
      logic                r_en_n;
      logic                r_step_out;
      logic                r_dir_out;
      logic                r_busy;
      logic                r_done;
      logic [STEP_W-1:0]   w_steps;

      assign w_steps = steps[gi*STEP_W +: STEP_W];

      // Per-channel controller; abort has priority over start and over ticks.
      always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
          r_state    <= ST_IDLE;
          r_cnt      <= '0;
          r_hold     <= '0;
          r_en_n     <= 1'b1;
          r_step_out <= 1'b0;
          r_dir_out  <= 1'b0;
          r_busy     <= 1'b0;
          r_done     <= 1'b1;
        end else begin
          r_step_out <= 1'b0;
          case (r_state)
            ST_IDLE: begin
              if (start[gi] && !abort[gi]) begin
                if (w_steps != '0) begin
                  r_cnt     <= w_steps;
                  r_dir_out <= dir_in[gi];
                  r_en_n    <= 1'b0;
                  r_busy    <= 1'b1;
                  r_done    <= 1'b0;
                  r_state   <= ST_MOVE;
                end else begin
                  // A zero-length move completes at once without energising.
                  r_done <= 1'b1;
                end
              end
            end
            ST_MOVE: begin
              if (abort[gi]) begin
                r_en_n  <= 1'b1;
                r_busy  <= 1'b0;
                r_done  <= 1'b1;
                r_state <= ST_IDLE;
              end else if (w_tick) begin
                r_step_out <= 1'b1;
                r_cnt      <= r_cnt - STEP_W'(1);
                if (r_cnt == STEP_W'(1)) begin
                  r_hold  <= HOLD_W'(HOLD_STEPS);
                  r_state <= ST_HOLD;
                end
              end
            end
            ST_HOLD: begin
              if (abort[gi] || (r_hold == '0)) begin
                r_en_n  <= 1'b1;
                r_busy  <= 1'b0;
                r_done  <= 1'b1;
                r_state <= ST_IDLE;
              end else if (w_tick) begin
                r_hold <= r_hold - HOLD_W'(1);
              end
            end
            default: begin
              r_en_n  <= 1'b1;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_state <= ST_IDLE;
            end
          endcase
        end
      end

      assign en_n[gi]     = r_en_n;
      assign step_out[gi] = r_step_out;
      assign dir_out[gi]  = r_dir_out;
      assign busy[gi]     = r_busy;
      assign done[gi]     = r_done;
    end
  endgenerate

  // Registered summary of all channel completion flags.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_all_done <= 1'b1;
    end else begin
      r_all_done <= &done;
    end
  end

  assign all_done = r_all_done;

endmodule

// File: tb/tb_multi_stepper_driver.sv
// Self-checking bench for multi_stepper_driver (2 channels, 3-tick hold).
module tb_multi_stepper_driver;

  localparam int NCH  = 2;
  localparam int SW   = 12;
  localparam int HOLD = 3;

  logic             clock = 1'b0;
  logic             reset_n = 1'b0;
  logic             step_clock = 1'b0;
  logic [NCH-1:0]   start = '0;
  logic [NCH-1:0]   dir_in = '0;
  logic [NCH*SW-1:0] steps = '0;
  logic [NCH-1:0]   abort = '0;
  logic [NCH-1:0]   en_n;
  logic [NCH-1:0]   step_out;
  logic [NCH-1:0]   dir_out;
  logic [NCH-1:0]   busy;
  logic [NCH-1:0]   done;
  logic             all_done;

  int n_checks = 0;
  int n_fail   = 0;
  int pulse_cnt [NCH];

  multi_stepper_driver #(
    .NUM_CH(NCH), .STEP_W(SW), .HOLD_STEPS(HOLD)
  ) dut (
    .clock(clock), .reset_n(reset_n), .step_clock(step_clock),
    .start(start), .dir_in(dir_in), .steps(steps), .abort(abort),
    .en_n(en_n), .step_out(step_out), .dir_out(dir_out),
    .busy(busy), .done(done), .all_done(all_done)
  );

  always #5 clock = ~clock;

  // Pulse counter: counts every clock cycle in which step_out is high.
  always @(negedge clock) begin
    for (int c = 0; c < NCH; c++) begin
      if (!reset_n) pulse_cnt[c] = 0;
      else if (step_out[c]) pulse_cnt[c] = pulse_cnt[c] + 1;
    end
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // One step_clock period: high 4 clocks, low 4 clocks.
  task automatic tick_once();
    @(negedge clock);
    step_clock = 1'b1;
    repeat (4) @(negedge clock);
    step_clock = 1'b0;
    repeat (4) @(negedge clock);
  endtask

  // Present start/abort for exactly one rising edge; returns on the following negedge.
  task automatic drive(input logic [1:0] st, input logic [1:0] dr,
                       input logic [SW-1:0] s0, input logic [SW-1:0] s1,
                       input logic [1:0] ab);
    @(negedge clock);
    start  = st;
    dir_in = dr;
    steps  = {s1, s0};
    abort  = ab;
    @(negedge clock);
    start  = '0;
    abort  = '0;
  endtask

  // ---------------- reference model (tick-count arithmetic) ----------------
  bit m_busy [NCH];
  bit m_done [NCH];
  bit m_dir  [NCH];
  int m_n    [NCH];
  int m_k    [NCH];
  int m_puls [NCH];

  task automatic model_reset();
    for (int c = 0; c < NCH; c++) begin
      m_busy[c] = 0; m_done[c] = 1; m_dir[c] = 0;
      m_n[c] = 0; m_k[c] = 0; m_puls[c] = 0;
    end
  endtask

  // A move of N steps pulses on ticks 1..N and is released after tick N+HOLD.
  task automatic model_tick();
    for (int c = 0; c < NCH; c++) begin
      if (m_busy[c]) begin
        m_k[c]++;
        if (m_k[c] <= m_n[c]) m_puls[c]++;
        if (m_k[c] >= m_n[c] + HOLD) begin
          m_busy[c] = 0;
          m_done[c] = 1;
        end
      end
    end
  endtask

  task automatic model_cmd(input int c, input bit st, input bit dr, input int n, input bit ab);
    if (ab) begin
      if (m_busy[c]) begin
        m_busy[c] = 0;
        m_done[c] = 1;
      end
    end else if (st && !m_busy[c]) begin
      if (n == 0) begin
        m_done[c] = 1;
      end else begin
        m_busy[c] = 1; m_done[c] = 0; m_dir[c] = dr;
        m_n[c] = n; m_k[c] = 0;
      end
    end
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic [1:0]    st;
    logic [1:0]    dr;
    logic [SW-1:0] s0;
    logic [SW-1:0] s1;
    logic [1:0]    ab;
    int            nt;
    int            p0;
    int            p1;
    logic [1:0]    busy;
    logic [1:0]    done;
    logic [1:0]    en_n;
    logic [1:0]    dir;
    logic          ad;
  } vec_t;

  vec_t vecs [8];

  initial begin
    int b0, b1;

    vecs[0] = '{2'b01, 2'b01, 12'd5,    12'd0, 2'b00, 7, 5, 0, 2'b01, 2'b10, 2'b10, 2'b01, 1'b0};
    vecs[1] = '{2'b00, 2'b00, 12'd0,    12'd0, 2'b00, 1, 0, 0, 2'b00, 2'b11, 2'b11, 2'b01, 1'b1};
    vecs[2] = '{2'b10, 2'b00, 12'd0,    12'd0, 2'b00, 2, 0, 0, 2'b00, 2'b11, 2'b11, 2'b01, 1'b1};
    vecs[3] = '{2'b11, 2'b10, 12'd3,    12'd7, 2'b00, 6, 3, 6, 2'b10, 2'b01, 2'b01, 2'b10, 1'b0};
    vecs[4] = '{2'b00, 2'b00, 12'd0,    12'd0, 2'b00, 4, 0, 1, 2'b00, 2'b11, 2'b11, 2'b10, 1'b1};
    vecs[5] = '{2'b01, 2'b01, 12'd4095, 12'd0, 2'b00, 2, 2, 0, 2'b01, 2'b10, 2'b10, 2'b11, 1'b0};
    vecs[6] = '{2'b00, 2'b00, 12'd0,    12'd0, 2'b01, 0, 0, 0, 2'b00, 2'b11, 2'b11, 2'b11, 1'b1};
    vecs[7] = '{2'b01, 2'b00, 12'd5,    12'd0, 2'b01, 2, 0, 0, 2'b00, 2'b11, 2'b11, 2'b11, 1'b1};

    // Reset state
    repeat (3) @(negedge clock);
    check("rst_en_n", en_n, 2'b11);
    check("rst_step_out", step_out, 2'b00);
    check("rst_dir_out", dir_out, 2'b00);
    check("rst_busy", busy, 2'b00);
    check("rst_done", done, 2'b11);
    check("rst_all_done", all_done, 1);
    reset_n = 1'b1;
    repeat (3) @(negedge clock);

    // Table-driven vectors
    for (int v = 0; v < 8; v++) begin
      b0 = pulse_cnt[0];
      b1 = pulse_cnt[1];
      drive(vecs[v].st, vecs[v].dr, vecs[v].s0, vecs[v].s1, vecs[v].ab);
      repeat (vecs[v].nt) tick_once();
      repeat (2) @(negedge clock);
      check($sformatf("v%0d_pulses0", v), pulse_cnt[0] - b0, vecs[v].p0);
      check($sformatf("v%0d_pulses1", v), pulse_cnt[1] - b1, vecs[v].p1);
      check($sformatf("v%0d_busy", v), busy, vecs[v].busy);
      check($sformatf("v%0d_done", v), done, vecs[v].done);
      check($sformatf("v%0d_en_n", v), en_n, vecs[v].en_n);
      check($sformatf("v%0d_dir_out", v), dir_out, vecs[v].dir);
      check($sformatf("v%0d_all_done", v), all_done, vecs[v].ad);
      $display("vector %0d: start=%b abort=%b ticks=%0d busy=%b done=%b en_n=%b", v,
               vecs[v].st, vecs[v].ab, vecs[v].nt, busy, done, en_n);
    end

    // Start latency and restart-while-busy (steps=4, second start steps=9 ignored)
    b0 = pulse_cnt[0];
    drive(2'b01, 2'b01, 12'd4, 12'd0, 2'b00);
    check("lat_busy", busy[0], 1);
    check("lat_en_n", en_n[0], 0);
    check("lat_done", done[0], 0);
    check("lat_dir", dir_out[0], 1);
    repeat (2) tick_once();
    drive(2'b01, 2'b00, 12'd9, 12'd0, 2'b00);
    repeat (6) tick_once();
    repeat (2) @(negedge clock);
    check("restart_pulses", pulse_cnt[0] - b0, 4);
    check("restart_dir", dir_out[0], 1);
    check("restart_busy", busy[0], 0);
    $display("sequence restart: pulses=%0d dir_out0=%b", pulse_cnt[0] - b0, dir_out[0]);

    // Zero-step start: no move entered
    drive(2'b10, 2'b00, 12'd0, 12'd0, 2'b00);
    check("zero_busy", busy[1], 0);
    check("zero_en_n", en_n[1], 1);
    check("zero_done", done[1], 1);
    $display("sequence zero-steps: busy1=%b done1=%b", busy[1], done[1]);

    // Abort after the 4th pulse of a 10-step move
    b0 = pulse_cnt[0];
    drive(2'b01, 2'b00, 12'd10, 12'd0, 2'b00);
    repeat (4) tick_once();
    check("abort_pre_pulses", pulse_cnt[0] - b0, 4);
    drive(2'b00, 2'b00, 12'd0, 12'd0, 2'b01);
    check("abort_en_n", en_n[0], 1);
    check("abort_busy", busy[0], 0);
    check("abort_done", done[0], 1);
    repeat (3) tick_once();
    check("abort_post_pulses", pulse_cnt[0] - b0, 4);
    $display("sequence abort: pulses=%0d", pulse_cnt[0] - b0);

    // Reset dropped mid-HOLD
    drive(2'b01, 2'b01, 12'd2, 12'd0, 2'b00);
    repeat (3) tick_once();
    check("hold_en_n", en_n[0], 0);
    check("hold_busy", busy[0], 1);
    @(negedge clock);
    #2 reset_n = 1'b0;
    #1;
    check("async_rst_en_n", en_n, 2'b11);
    check("async_rst_busy", busy, 2'b00);
    check("async_rst_step", step_out, 2'b00);
    check("async_rst_done", done, 2'b11);
    check("async_rst_dir", dir_out, 2'b00);
    check("async_rst_all_done", all_done, 1);
    $display("sequence reset-in-hold: en_n=%b busy=%b", en_n, busy);
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    repeat (3) @(negedge clock);

    // Randomised rounds against the reference model
    model_reset();
    for (int r = 0; r < 40; r++) begin
      logic [1:0]    st, dr, ab;
      logic [SW-1:0] sv [NCH];
      int            nt;
      for (int c = 0; c < NCH; c++) begin
        st[c] = ($urandom_range(0, 3) != 0);
        dr[c] = $urandom_range(0, 1);
        ab[c] = ($urandom_range(0, 5) == 0);
        if ($urandom_range(0, 9) == 0) sv[c] = SW'($urandom_range(10, 4095));
        else sv[c] = SW'($urandom_range(0, 9));
      end
      drive(st, dr, sv[0], sv[1], ab);
      for (int c = 0; c < NCH; c++) model_cmd(c, st[c], dr[c], int'(sv[c]), ab[c]);
      nt = $urandom_range(1, 4);
      for (int t = 0; t < nt; t++) begin
        tick_once();
        model_tick();
      end
      repeat (2) @(negedge clock);
      for (int c = 0; c < NCH; c++) begin
        check($sformatf("r%0d_c%0d_busy", r, c), busy[c], m_busy[c]);
        check($sformatf("r%0d_c%0d_en_n", r, c), en_n[c], !m_busy[c]);
        check($sformatf("r%0d_c%0d_done", r, c), done[c], m_done[c]);
        check($sformatf("r%0d_c%0d_dir", r, c), dir_out[c], m_dir[c]);
        check($sformatf("r%0d_c%0d_pulses", r, c), pulse_cnt[c], m_puls[c]);
      end
      check($sformatf("r%0d_all_done", r), all_done, m_done[0] & m_done[1]);
      $display("round %0d: start=%b abort=%b steps=%0d/%0d ticks=%0d busy=%b pulses=%0d/%0d",
               r, st, ab, sv[0], sv[1], nt, busy, pulse_cnt[0], pulse_cnt[1]);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/multi_stepper_driver.md
MULTI_STEPPER_DRIVER -- requirements
Module: multi_stepper_driver

Interface
REQ-001 SHALL have parameter NUM_CH, default 2: number of independent motor channels (1..8).
REQ-002 SHALL have parameter STEP_W, default 12: width of each channel's step-count field.
REQ-003 SHALL have parameter HOLD_STEPS, default 50: step_clock periods the coils stay energised after the last step.
REQ-004 SHALL have port clock  in  1  system clock; all logic on its rising edge.
REQ-005 SHALL have port reset_n  in  1  reset, asynchronous and active-low.
REQ-006 SHALL have port step_clock  in  1  step-rate clock, asynchronous to clock.
REQ-007 SHALL have port start  in  NUM_CH  per-channel move request; sampled only in IDLE.
REQ-008 SHALL have port dir_in  in  NUM_CH  per-channel direction; captured with start.
REQ-009 SHALL have port steps  in  NUM_CH*STEP_W  packed step counts; channel i uses bits [i*STEP_W +: STEP_W].
REQ-010 SHALL have port abort  in  NUM_CH  per-channel immediate stop.
REQ-011 SHALL have port en_n  out  NUM_CH  active-low driver enable, registered.
REQ-012 SHALL have port step_out  out  NUM_CH  one-clock step pulse to the driver, registered.
REQ-013 SHALL have port dir_out  out  NUM_CH  latched direction, registered.
REQ-014 SHALL have port busy  out  NUM_CH  high while the channel is in MOVE or HOLD.
REQ-015 SHALL have port done  out  NUM_CH  sticky completion flag; cleared by an accepted start.
REQ-016 SHALL have port all_done  out  1  AND of all done bits, registered.

Function
REQ-017 SHALL pass step_clock through a 2-flop synchroniser; a "tick" is a one-clock pulse on the synchronised rising edge, shared by all channels.
REQ-018 Each channel SHALL run an independent FSM with states IDLE, MOVE and HOLD, plus a STEP_W-bit step counter and a hold counter wide enough for HOLD_STEPS.
REQ-019 IDLE with start=1, abort=0 and steps!=0 at cycle T SHALL load the counter, latch dir_out, and at T+1 drive en_n=0, busy=1, done=0, state MOVE.
REQ-020 IDLE with start=1 and steps==0 SHALL leave en_n=1 and set done=1 at T+1 without entering MOVE.
REQ-021 In MOVE, each tick SHALL produce step_out=1 for exactly the next clock cycle and decrement the counter.
REQ-022 The tick that decrements the counter from 1 to 0 SHALL emit the final step_out and enter HOLD with the hold counter set to HOLD_STEPS.
REQ-023 In HOLD, en_n SHALL stay 0 and step_out SHALL stay 0; each tick SHALL decrement the hold counter.
REQ-024 On reaching 0 in HOLD, the next cycle SHALL have en_n=1, busy=0, done=1, state IDLE.
REQ-025 With HOLD_STEPS=0, the channel SHALL go from MOVE directly to the REQ-024 outputs one cycle after the final step pulse.
REQ-026 start while busy=1 SHALL be ignored, with no effect on the counter, dir_out or done.
REQ-027 abort in MOVE or HOLD SHALL produce en_n=1, step_out=0, busy=0, done=1, state IDLE on the next cycle, and no further step pulse.
REQ-028 abort and start asserted together in IDLE: abort SHALL win and the start SHALL be discarded.
REQ-029 Channels SHALL be fully independent; a start, abort or completion on one channel SHALL NOT alter another channel's state or outputs.
REQ-030 The counter SHALL never wrap: a decrement at 0 is impossible by construction, and steps up to 2^STEP_W-1 SHALL be supported.

Reset
REQ-031 reset_n=0 SHALL asynchronously force every channel to IDLE with en_n=all 1s, step_out=0, dir_out=0, busy=0, done=all 1s, all_done=1, all counters 0, and synchroniser flops 0.
REQ-032 Reset asserted mid-move SHALL de-energise immediately (en_n=1) with no trailing step pulse.
REQ-033 The first tick SHALL be detected only after at least 2 clocks following reset_n release.

Verification
REQ-034 NUM_CH=2, STEP_W=12, HOLD_STEPS=3; start[0] with steps=5, dir=1 -> exactly 5 step_out[0] pulses and dir_out[0]=1; en_n[0] rises 3 ticks after the 5th pulse; done[0]=1; channel 1 untouched.
REQ-035 start[1] with steps=0 -> done[1]=1 one cycle later; en_n[1] stays 1; zero step pulses.
REQ-036 start[0] steps=10, abort[0] after the 4th pulse -> exactly 4 pulses, en_n[0]=1 next cycle, done[0]=1, busy[0]=0.
REQ-037 Start both channels (steps=3 and 7) in the same cycle -> independent pulse counts of 3 and 7; all_done=1 only after channel 1 finishes HOLD.
REQ-038 Re-assert start[0] with steps=9 during MOVE of a steps=4 move -> exactly 4 pulses total, and the second start is ignored.
REQ-039 Drop reset_n mid-HOLD -> en_n, busy and step_out return to reset values combinationally before the next clock edge.
